// File: rtl/face_instr_issuer.sv
// FACE accelerator instruction sequencer: fetches a program from BRAM and issues it.
// Define FACE_ISSUE_WDOG_EN to add a busy-wait watchdog that sets err on timeout.
module face_instr_issuer #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned LEN_W        = 16,
    parameter logic [6:0]  SYS_OPCODE   = 7'h0B,
    parameter logic [6:0]  SHA_OPCODE   = 7'h2B,
    parameter logic [7:0]  NOWAIT_SYS   = 8'h01,
    parameter logic [7:0]  NOWAIT_SHA   = 8'h01,
    parameter int unsigned GUARD_CYCLES = 2
`ifdef FACE_ISSUE_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES  = 2**20
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] prog_base,
    input  logic [LEN_W-1:0]  prog_len,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_ren,
    input  logic [31:0]       prog_rdata,
    output logic [31:0]       instr,
    output logic              next_instr,
    input  logic [3:0]        bitbusy,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  issued_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DRAIN,
        S_ISSUE,
        S_GUARD,
        S_FINAL
    } state_t;

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  pc;
    logic [LEN_W-1:0]  pc_inc;
    logic [31:0]       ir;
    logic              ir_nowait;
    logic [3:0]        guard_cnt;
    logic              accept;
    logic              timeout;
    logic              wd_hit;
    logic              acc_idle;
    logic [6:0]        ld_op;
    logic [2:0]        ld_func;
    logic              ld_nowait;

    assign acc_idle  = (bitbusy == 4'b0000);
    assign pc_inc    = pc + LEN_W'(1);
    assign ld_op     = prog_rdata[6:0];
    assign ld_func   = prog_rdata[9:7];
    assign ld_nowait = ((ld_op == SYS_OPCODE) && NOWAIT_SYS[ld_func]) ||
                       ((ld_op == SHA_OPCODE) && NOWAIT_SHA[ld_func]);

    assign prog_ren   = (state_q == S_FETCH);
    assign prog_addr  = prog_ren ? base + ADDR_W'(pc) : '0;
    assign next_instr = (state_q == S_ISSUE);
    assign instr      = next_instr ? ir : 32'd0;

`ifdef FACE_ISSUE_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES) + 1;

    logic [WD_W-1:0] wd_cnt;

    assign wd_hit = (wd_cnt == WD_W'(WDOG_CYCLES - 1));

    // Restarts on every state change so DRAIN and FINAL each get a full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state_d != state_q) begin
            wd_cnt <= '0;
        end else if (state_q == S_DRAIN || state_q == S_FINAL) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        accept  = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (prog_len == '0) ? S_FINAL : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = ld_nowait ? S_ISSUE : S_DRAIN;
            S_DRAIN: begin
                if (acc_idle) begin
                    state_d = S_ISSUE;
                end else if (wd_hit) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!ir_nowait) begin
                    state_d = S_GUARD;
                end else begin
                    state_d = (pc_inc == len) ? S_FINAL : S_FETCH;
                end
            end
            S_GUARD: begin
                if (guard_cnt == GUARD_LAST) begin
                    state_d = (pc == len) ? S_FINAL : S_FETCH;
                end
            end
            S_FINAL: begin
                if (acc_idle) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (wd_hit) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            done    = 1'b0;
            accept  = 1'b0;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base       <= '0;
            len        <= '0;
            pc         <= '0;
            ir         <= '0;
            ir_nowait  <= 1'b0;
            guard_cnt  <= '0;
            issued_cnt <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                base       <= prog_base;
                len        <= prog_len;
                pc         <= '0;
                issued_cnt <= '0;
                err        <= 1'b0;
                busy       <= 1'b1;
            end
            if (state_q == S_LOAD) begin
                ir        <= prog_rdata;
                ir_nowait <= ld_nowait;
            end
            if (state_q == S_ISSUE) begin
                pc         <= pc_inc;
                issued_cnt <= issued_cnt + LEN_W'(1);
                guard_cnt  <= '0;
            end
            if (state_q == S_GUARD) begin
                guard_cnt <= guard_cnt + 4'd1;
            end
            if (done || timeout || abort) begin
                busy <= 1'b0;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_face_instr_issuer.sv
// Scoreboard bench for face_instr_issuer: random programs, emulated accelerator busy.
// Watchdog scenario runs only when FACE_ISSUE_WDOG_EN is defined.
`timescale 1ns/1ps
module tb_face_instr_issuer;

    localparam int G = 2;
    localparam logic [6:0] SYS = 7'h0B;
    localparam logic [6:0] SHA = 7'h2B;
    localparam logic [7:0] NW_SYS = 8'h01;
    localparam logic [7:0] NW_SHA = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] prog_base = '0;
    logic [15:0] prog_len = '0;
    logic [31:0] prog_addr;
    logic        prog_ren;
    logic [31:0] prog_rdata = '0;
    logic [31:0] instr;
    logic        next_instr;
    logic [3:0]  bitbusy;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] issued_cnt;

    logic [3:0]  bb_emu = '0;
    logic [3:0]  bb_dir = '0;
    logic        emu_en = 1'b0;
    logic [31:0] mem [256];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_pulses = 0;
    int n_done = 0;
    int last_pulse = 0;
    int done_cyc = 0;
    int t0 = 0;
    int emu_d = 0;
    bit first_pulse = 1'b1;
    bit last_nw = 1'b0;
    logic [3:0] prev_bb = '0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];
    int          exp_done[$];

    assign bitbusy = bb_emu | bb_dir;

    face_instr_issuer #(
        .GUARD_CYCLES(G)
`ifdef FACE_ISSUE_WDOG_EN
        , .WDOG_CYCLES(64)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .prog_base(prog_base),
        .prog_len(prog_len),
        .prog_addr(prog_addr),
        .prog_ren(prog_ren),
        .prog_rdata(prog_rdata),
        .instr(instr),
        .next_instr(next_instr),
        .bitbusy(bitbusy),
        .busy(busy),
        .done(done),
        .err(err),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (prog_ren) prog_rdata <= mem[prog_addr[7:0]];
    end

    function automatic bit is_nowait(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f;
        logic [7:0] ms;
        logic [7:0] mh;
        op = w[6:0];
        f  = w[9:7];
        ms = NW_SYS;
        mh = NW_SHA;
        return (op == SYS && ms[f]) || (op == SHA && mh[f]);
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f);
        logic [31:0] w;
        w = $urandom;
        w[6:0] = op;
        w[9:7] = f;
        return w;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        case ($urandom_range(0, 2))
            0: op = SYS;
            1: op = SHA;
            default: begin
                op = 7'($urandom_range(0, 127));
                if (op == SYS || op == SHA) op = 7'h33;
            end
        endcase
        return mk(op, 3'($urandom_range(0, 7)));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_ge(input string nm, input int act, input int lim);
        n_cmp++;
        if (act < lim) begin
            n_bad++;
            $display("FAIL %s: got %0d want >= %0d (cycle %0d)", nm, act, lim, cyc);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        n_cmp++;
        if (act > lim) begin
            n_bad++;
            $display("FAIL %s: got %0d want <= %0d (cycle %0d)", nm, act, lim, cyc);
        end
    endtask

    task automatic flush();
        exp_addr.delete();
        exp_instr.delete();
        exp_done.delete();
    endtask

    task automatic launch(input logic [31:0] base, input int len);
        logic [31:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 32'(i);
            exp_addr.push_back(a);
            exp_instr.push_back(mem[a[7:0]]);
        end
        exp_done.push_back(len);
        @(posedge clk); #1;
        prog_base = base;
        prog_len = 16'(len);
        start = 1'b1;
        first_pulse = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_after_start", 32'(err), 32'd0);
        chk("cnt_after_start", 32'(issued_cnt), 32'd0);
    endtask

    task automatic finish_run(input int len);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: busy still %b after %0d cycles", busy, k);
            @(posedge clk); #1 abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
            flush();
        end
        chk("issued_cnt_end", 32'(issued_cnt), 32'(len));
        chk("err_end", 32'(err), 32'd0);
        chk("queue_drained", 32'(exp_instr.size() + exp_done.size()), 32'd0);
    endtask

    task automatic wait_pulse(input int p0);
        int k;
        k = 0;
        while (n_pulses <= p0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (n_pulses <= p0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_timeout: no next_instr within %0d cycles", k);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents fetch/issue/done.
    initial begin
        logic [31:0] e;
        bit nw;
        int gap;
        int req;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_bb = bitbusy;
                continue;
            end
            if (prog_ren) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_fetch: got addr %0h want none", prog_addr);
                end else begin
                    e = exp_addr.pop_front();
                    chk("prog_addr", prog_addr, e);
                end
            end
            if (next_instr) begin
                if (exp_instr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_issue: got %0h want none", instr);
                end else begin
                    e = exp_instr.pop_front();
                    chk("instr", instr, e);
                end
                nw = is_nowait(instr);
                if (!nw) chk("drain_bitbusy", 32'(prev_bb), 32'd0);
                if (!first_pulse) begin
                    gap = cyc - last_pulse;
                    req = 3 + (last_nw ? 0 : G);
                    if (nw) chk("issue_gap", 32'(gap), 32'(req));
                    else chk_ge("issue_gap_wait", gap, req + 1);
                end
                first_pulse = 1'b0;
                last_pulse = cyc;
                last_nw = nw;
                n_pulses++;
            end else begin
                chk("nop_instr", instr, 32'd0);
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done want none");
                end else begin
                    req = exp_done.pop_front();
                    chk("issued_cnt_done", 32'(issued_cnt), 32'(req));
                end
                chk("done_bitbusy", 32'(bitbusy), 32'd0);
                done_cyc = cyc;
                n_done++;
            end
            prev_bb = bitbusy;
        end
    end

    // Accelerator model: raises busy one cycle after sampling a waiting-class instr.
    initial begin
        forever begin
            @(negedge clk);
            if (emu_en && rst_n && next_instr && !is_nowait(instr)) begin
                emu_d = $urandom_range(0, 8);
                @(posedge clk); #1;
                for (int k = 0; k < emu_d; k++) begin
                    bb_emu = 4'(1 << $urandom_range(0, 3));
                    @(posedge clk); #1;
                end
                bb_emu = '0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int d0;
        int c0;
        int len;
        int k;
        logic [31:0] base;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_next", 32'(next_instr), 32'd0);
        chk("rst_ren", 32'(prog_ren), 32'd0);
        chk("rst_addr", prog_addr, 32'd0);
        chk("rst_cnt", 32'(issued_cnt), 32'd0);
        rst_n = 1'b1;

        // three config-only words back to back
        for (int i = 0; i < 3; i++) mem[16 + i] = mk(SYS, 3'd0);
        p0 = n_pulses;
        launch(32'd16, 3);
        finish_run(3);
        chk("t1_pulses", 32'(n_pulses - p0), 32'd3);
        chk("t1_done_lat", 32'(done_cyc - last_pulse), 32'd1);

        // waiting word followed by 10 cycles of accelerator busy
        mem[32] = mk(SYS, 3'd1);
        mem[33] = mk(SHA, 3'd3);
        p0 = n_pulses;
        launch(32'd32, 2);
        wait_pulse(p0);
        c0 = last_pulse;
        #1 bb_dir = 4'b0100;
        repeat (10) @(posedge clk);
        #1 bb_dir = 4'b0000;
        finish_run(2);
        chk("t2_gap", 32'(last_pulse - c0), 32'd12);

        // empty program
        p0 = n_pulses;
        d0 = n_done;
        launch(32'd40, 0);
        finish_run(0);
        chk("t3_done", 32'(n_done - d0), 32'd1);
        chk("t3_pulses", 32'(n_pulses - p0), 32'd0);
        chk_le("t3_done_lat", done_cyc - t0, 3);

        // abort while draining
        mem[48] = mk(SYS, 3'd2);
        mem[49] = mk(SYS, 3'd0);
        bb_dir = 4'b0010;
        d0 = n_done;
        launch(32'd48, 2);
        repeat (6) @(posedge clk);
        #1 abort = 1'b1;
        flush();
        @(posedge clk); #1 abort = 1'b0;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_instr", instr, 32'd0);
        repeat (5) @(posedge clk);
        chk("t4_no_done", 32'(n_done - d0), 32'd0);
        chk("t4_cnt_held", 32'(issued_cnt), 32'd0);
        bb_dir = 4'b0000;
        launch(32'd48, 2);
        finish_run(2);

        // start and abort together: abort wins
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);

        // start mid-run with another base is ignored
        for (int i = 0; i < 6; i++) mem[64 + i] = rand_instr();
        launch(32'd64, 6);
        repeat (4) @(posedge clk);
        #1 prog_base = 32'd200;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_run(6);

        // address wrap
        for (int i = 0; i < 256; i++) mem[i] = mk(SYS, 3'd0);
        launch(32'hFFFF_FFFE, 4);
        finish_run(4);

        // reset mid-run
        launch(32'd80, 4);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_instr", instr, 32'd0);
        chk("rst_mid_next", 32'(next_instr), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        flush();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // random programs with emulated accelerator busy
        emu_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = rand_instr();
            len = $urandom_range(1, 8);
            base = $urandom;
            if (r % 8 == 0) base = 32'hFFFF_FFFC;
            launch(base, len);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                prog_base = base + 32'd77;
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            finish_run(len);
        end
        emu_en = 1'b0;
        repeat (12) @(posedge clk);

`ifdef FACE_ISSUE_WDOG_EN
        // accelerator stuck busy: watchdog must fire
        mem[90] = mk(SYS, 3'd4);
        bb_dir = 4'b0100;
        d0 = n_done;
        launch(32'd90, 1);
        k = 0;
        while (busy === 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_lat", 32'(cyc - t0), 32'd67);
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        flush();
        bb_dir = 4'b0000;
        mem[91] = mk(SYS, 3'd0);
        launch(32'd91, 1);
        finish_run(1);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
